// File: rtl/seg7_scan_pkg.sv
// Shared types and constants for the seg7_scan 4-digit multiplexed display driver.
package seg7_scan_pkg;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam logic [1:0] DIG_SEC_0 = 2'd0;
    localparam logic [1:0] DIG_SEC_1 = 2'd1;
    localparam logic [1:0] DIG_MIN_0 = 2'd2;
    localparam logic [1:0] DIG_MIN_1 = 2'd3;

    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [3:0] dig_onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

endpackage

// File: rtl/seg7_scan_tmr.sv
// Loadable dwell down-counter for seg7_scan; last is high while the count sits at zero.
module seg7_scan_tmr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt_r;

    // Reload on state entry, otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last = (cnt_r == '0);

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame input capture and dp indicators.
// Define SEG7_SCAN_GAP_EN to insert BLN blank cycles after every digit (anti-ghosting).
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int DWN     = 256,
    parameter int BLN     = 16,
    parameter int BLK     = 64,
    parameter int SEG_POL = 1,
    parameter int DIG_POL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] sec_0,
    input  logic [6:0] sec_1,
    input  logic [6:0] min_0,
    input  logic [6:0] min_1,
    input  logic       s_run,
    input  logic       s_hld,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] dig,
    output logic       frame
);

    localparam int CW  = $clog2(max2(DWN, BLN));
    localparam int FCW = $clog2(2 * BLK);

    localparam logic [CW-1:0]  DWN_M1 = CW'(DWN - 1);
`ifdef SEG7_SCAN_GAP_EN
    localparam logic [CW-1:0]  BLN_M1 = CW'(BLN - 1);
    localparam state_t         RST_STATE = GAP;
`else
    localparam state_t         RST_STATE = SHOW;
`endif
    localparam logic [FCW-1:0] BLK_V  = FCW'(BLK);
    localparam logic [FCW-1:0] FC_TOP = FCW'(2 * BLK - 1);
    localparam logic           SEG_ACT = (SEG_POL != 0);
    localparam logic           DIG_ACT = (DIG_POL != 0);

    state_t         state_r, state_n;
    logic [1:0]     idx_r, idx_n;
    logic           armed_r;
    logic           ld_s;
    logic [CW-1:0]  ld_val_s;
    logic           tmr_last_s;
    logic           cap_s;

    logic [6:0]     pat_r [4];
    logic           run_r, hld_r, blink_r;
    logic [FCW-1:0] fcnt_r;

    logic [6:0]     pat_s;
    logic           dp_s;
    logic [3:0]     dig_s;

    seg7_scan_tmr #(.W(CW)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (ld_s),
        .load_val (ld_val_s),
        .last     (tmr_last_s)
    );

    // Next-state and timer reload; the first edge after reset starts the scan
    always_comb begin
        state_n  = state_r;
        idx_n    = idx_r;
        ld_s     = 1'b0;
        ld_val_s = DWN_M1;
        if (!armed_r) begin
            ld_s = 1'b1;
`ifdef SEG7_SCAN_GAP_EN
            state_n  = GAP;
            idx_n    = DIG_MIN_1;
            ld_val_s = BLN_M1;
`else
            state_n  = SHOW;
            idx_n    = DIG_SEC_0;
`endif
        end else if (tmr_last_s) begin
            ld_s = 1'b1;
            case (state_r)
`ifdef SEG7_SCAN_GAP_EN
                SHOW: begin
                    state_n  = GAP;
                    ld_val_s = BLN_M1;
                end
                GAP: begin
                    state_n = SHOW;
                    idx_n   = idx_r + 2'd1;
                end
`else
                SHOW: begin
                    state_n = SHOW;
                    idx_n   = idx_r + 2'd1;
                end
`endif
                default: begin
                    state_n = SHOW;
                    idx_n   = DIG_SEC_0;
                end
            endcase
        end else begin
            ld_s = 1'b0;
        end
    end

    assign cap_s = ld_s && (state_n == SHOW) && (idx_n == DIG_SEC_0);

    // FSM state, digit index and start-up flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RST_STATE;
            idx_r   <= DIG_MIN_1;
            armed_r <= 1'b0;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
            armed_r <= 1'b1;
        end
    end

    // Frame shadows and blink frame counter, loaded on entry to SHOW(0)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_r[0] <= SEG_OFF;
            pat_r[1] <= SEG_OFF;
            pat_r[2] <= SEG_OFF;
            pat_r[3] <= SEG_OFF;
            run_r    <= 1'b0;
            hld_r    <= 1'b0;
            blink_r  <= 1'b0;
            fcnt_r   <= '0;
        end else if (cap_s) begin
            pat_r[0] <= sec_0;
            pat_r[1] <= sec_1;
            pat_r[2] <= min_0;
            pat_r[3] <= min_1;
            run_r    <= s_run;
            hld_r    <= s_hld;
            blink_r  <= (fcnt_r < BLK_V);
            fcnt_r   <= (fcnt_r == FC_TOP) ? '0 : fcnt_r + FCW'(1);
        end else begin
            fcnt_r   <= fcnt_r;
        end
    end

    // Active-high view of what the outputs show after this edge; digit 0 bypasses the shadow on capture
    always_comb begin
        pat_s = SEG_OFF;
        dp_s  = 1'b0;
        dig_s = 4'b0000;
        if (state_n == SHOW) begin
            dig_s = dig_onehot(idx_n);
            case (idx_n)
                DIG_SEC_0: begin
                    pat_s = cap_s ? sec_0 : pat_r[0];
                    dp_s  = cap_s ? s_hld : hld_r;
                end
                DIG_SEC_1: pat_s = pat_r[1];
                DIG_MIN_0: begin
                    pat_s = pat_r[2];
                    dp_s  = run_r ? blink_r : 1'b1;
                end
                DIG_MIN_1: pat_s = pat_r[3];
                default:   pat_s = SEG_OFF;
            endcase
        end else begin
            dig_s = 4'b0000;
        end
    end

    // Output registers; polarity is applied only here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg   <= {7{~SEG_ACT}};
            dp    <= ~SEG_ACT;
            dig   <= {4{~DIG_ACT}};
            frame <= 1'b0;
        end else begin
            seg   <= pat_s ^ {7{~SEG_ACT}};
            dp    <= dp_s ^ ~SEG_ACT;
            dig   <= dig_s ^ {4{~DIG_ACT}};
            frame <= cap_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: per-frame expected digit intervals are queued by the stimulus
// and compared by a monitor that slices the output stream into constant {dig,seg,dp} intervals.
`timescale 1ns/1ps
module tb_seg7_scan;

    localparam int DWN = 256;
    localparam int BLN = 16;
    localparam int BLK = 2;
`ifdef SEG7_SCAN_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif
    localparam int PERIOD = GAP_EN ? 4 * (DWN + BLN) : 4 * DWN;
    localparam int FIRST  = GAP_EN ? BLN + 1 : 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] sec_0, sec_1, min_0, min_1;
    logic       s_run, s_hld;
    logic [6:0] seg, seg2;
    logic       dp, dp2, frame, frame2;
    logic [3:0] dig, dig2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
        int         len;
    } iv_t;
    iv_t exp_q[$];

    always #5 clk = ~clk;

    seg7_scan #(.DWN(DWN), .BLN(BLN), .BLK(BLK), .SEG_POL(1), .DIG_POL(1)) dut (
        .clk(clk), .rst(rst), .sec_0(sec_0), .sec_1(sec_1), .min_0(min_0), .min_1(min_1),
        .s_run(s_run), .s_hld(s_hld), .seg(seg), .dp(dp), .dig(dig), .frame(frame)
    );

    seg7_scan #(.DWN(4), .BLN(2), .BLK(1), .SEG_POL(0), .DIG_POL(0)) dut_inv (
        .clk(clk), .rst(rst), .sec_0(sec_0), .sec_1(sec_1), .min_0(min_0), .min_1(min_1),
        .s_run(s_run), .s_hld(s_hld), .seg(seg2), .dp(dp2), .dig(dig2), .frame(frame2)
    );

    // Expected display of frame k, built from the values captured at its start
    task automatic push_frame(input int k);
        logic [6:0] p [4];
        iv_t iv;
        p[0] = sec_0; p[1] = sec_1; p[2] = min_0; p[3] = min_1;
        for (int d = 0; d < 4; d++) begin
            iv.dig = 4'(1 << d);
            iv.seg = p[d];
            iv.len = DWN;
            if (d == 0)      iv.dp = s_hld;
            else if (d == 2) iv.dp = s_run ? ((k % (2 * BLK)) < BLK) : 1'b1;
            else             iv.dp = 1'b0;
            exp_q.push_back(iv);
            if (GAP_EN) begin
                iv.dig = 4'b0000; iv.seg = 7'h00; iv.dp = 1'b0; iv.len = BLN;
                exp_q.push_back(iv);
            end
        end
    endtask

    // Drive random input changes; queue a frame whenever the upcoming edge is a frame start
    task automatic run_frames(input int nf);
        int k = 0;
        int r;
        for (int e = 1; e <= FIRST + nf * PERIOD; e++) begin
            if ($urandom_range(0, 199) == 0) begin
                r = $urandom_range(0, 10);
                case (r)
                    0, 4: sec_0 = 7'($urandom);
                    1, 5: sec_1 = 7'($urandom);
                    2, 6: min_0 = 7'($urandom);
                    3, 7: min_1 = 7'($urandom);
                    8, 9: s_hld = ~s_hld;
                    default: s_run = ~s_run;
                endcase
            end
            if (e >= FIRST && ((e - FIRST) % PERIOD) == 0) begin
                push_frame(k);
                k++;
            end
            @(negedge clk);
        end
    endtask

    logic [3:0] cur_dig;
    logic [6:0] cur_seg;
    logic       cur_dp;
    int         cur_len, rel_cnt, last_frame;
    bit         tracking, seen_frame;
    iv_t        ev;

    // Monitor: reset levels, one-hot, frame timing and interval scoreboard
    initial begin
        tracking = 0; seen_frame = 0; rel_cnt = 0; last_frame = 0; cur_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tracking = 0; seen_frame = 0; rel_cnt = 0;
                checks++;
                if ({dig, seg, dp, frame} !== {4'h0, 7'h00, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL reset_off: dig=%b seg=%h dp=%b frame=%b, want all 0", dig, seg, dp, frame);
                end
                checks++;
                if ({dig2, seg2, dp2} !== {4'hF, 7'h7F, 1'b1}) begin
                    errors++;
                    $display("FAIL reset_inv: dig=%b seg=%h dp=%b, want all 1", dig2, seg2, dp2);
                end
            end else begin
                rel_cnt++;
                checks++;
                if ($countones(dig) > 1 || $countones(~dig2) > 1) begin
                    errors++;
                    $display("FAIL onehot: dig=%b dig_inv=%b, want at most one active", dig, dig2);
                end
                if (dig2 === 4'hF) begin
                    checks++;
                    if ({seg2, dp2} !== 8'hFF) begin
                        errors++;
                        $display("FAIL idle_inv: seg=%h dp=%b, want 7f/1", seg2, dp2);
                    end
                end
                if (frame) begin
                    checks++;
                    if (!seen_frame) begin
                        if (rel_cnt != FIRST) begin
                            errors++;
                            $display("FAIL first_frame: at cycle %0d, want %0d", rel_cnt, FIRST);
                        end
                    end else if (rel_cnt - last_frame != PERIOD) begin
                        errors++;
                        $display("FAIL frame_period: %0d, want %0d", rel_cnt - last_frame, PERIOD);
                    end
                    checks++;
                    if (dig !== 4'b0001) begin
                        errors++;
                        $display("FAIL frame_dig: dig=%b at frame, want 0001", dig);
                    end
                    seen_frame = 1;
                    last_frame = rel_cnt;
                end
                if (tracking) begin
                    if ({dig, seg, dp} === {cur_dig, cur_seg, cur_dp}) begin
                        cur_len++;
                    end else begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL interval: got dig=%b seg=%h dp=%b len=%0d, want none queued",
                                     cur_dig, cur_seg, cur_dp, cur_len);
                        end else begin
                            ev = exp_q.pop_front();
                            if (ev.dig !== cur_dig || ev.seg !== cur_seg || ev.dp !== cur_dp || ev.len != cur_len) begin
                                errors++;
                                $display("FAIL interval: got dig=%b seg=%h dp=%b len=%0d, want dig=%b seg=%h dp=%b len=%0d",
                                         cur_dig, cur_seg, cur_dp, cur_len, ev.dig, ev.seg, ev.dp, ev.len);
                            end
                        end
                        cur_dig = dig; cur_seg = seg; cur_dp = dp; cur_len = 1;
                    end
                end else if (frame) begin
                    tracking = 1;
                    cur_dig = dig; cur_seg = seg; cur_dp = dp; cur_len = 1;
                end
            end
        end
    end

    // Stimulus: power-up, random frames, asynchronous reset during SHOW(1), restart
    initial begin
        bit found;
        sec_0 = 7'h3F; sec_1 = 7'h06; min_0 = 7'h5B; min_1 = 7'h4F;
        s_run = 1'b1; s_hld = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        run_frames(10);

        found = 0;
        for (int i = 0; i < 2 * PERIOD && !found; i++) begin
            @(negedge clk);
            if (dig === 4'b0010) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_show1: dig=%b, want 0010 within %0d cycles", dig, 2 * PERIOD);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dig, seg, dp, frame} !== {4'h0, 7'h00, 1'b0, 1'b0} || {dig2, seg2, dp2} !== {4'hF, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: dig=%b seg=%h dp=%b inv=%b/%h/%b, want off", dig, seg, dp, dig2, seg2, dp2);
        end
        repeat (2) @(negedge clk);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        run_frames(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit
    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed 4-digit 7-segment display driver, directly downstream of the stopwatch core. It captures the four segment patterns (`sec_0`, `sec_1`, `min_0`, `min_1`) and the `s_run`/`s_hld` indicators once per frame. It then scans them one digit at a time onto a shared segment bus with one-hot digit enables, and drives the decimal points as run/hold indicators.

## Interface
- `DWN`, 256: dwell cycles per digit, ≥2.
- `BLN`, 16: blanking cycles between digits, ≥1; used only with gap enabled.
- `BLK`, 64: frames per blink half-period for the run indicator, ≥1.
- `SEG_POL`, 1: segment/dp active level (1 = active-high, 0 = active-low).
- `DIG_POL`, 1: digit-enable active level.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `sec_0`, `sec_1`, `min_0`, `min_1`  in  7 each  segment patterns, bit0 = segment a … bit6 = segment g, 1 = lit.
- `s_run`  in  1  stopwatch running.
- `s_hld`  in  1  display hold active.
- `seg`  out  7  shared segment bus, polarity per `SEG_POL`.
- `dp`  out  1  shared decimal point, polarity per `SEG_POL`.
- `dig`  out  4  digit enables, one-hot or all-off; `dig[0]`=sec_0, `dig[1]`=sec_1, `dig[2]`=min_0, `dig[3]`=min_1; polarity per `DIG_POL`.
- `frame`  out  1  one-cycle pulse on the first cycle of each frame.

## Operation
- FSM states: `GAP`, `SHOW`. It has a 2-bit digit index `idx` and a dwell counter `cnt` of width `$clog2(max(DWN,BLN))`.
- `SHOW(i)`: lasts exactly `DWN` cycles.
  - `dig` drives only digit i; `seg` drives `shadow[i]`.
  - On its last cycle, the next state is `GAP` with the gap enabled, or `SHOW((i+1) mod 4)` without it.
- `GAP`: lasts exactly `BLN` cycles with `dig` all-off and `seg`/`dp` off. It then enters `SHOW((idx+1) mod 4)`.
- Frame capture: on the edge entering `SHOW(0)`:
  - All four patterns, `s_run` and `s_hld` load into shadow registers.
  - The output for digit 0 uses the newly captured value.
  - Input changes mid-frame are not displayed until the next frame.
- Decimal points:
  - Digit 0 dp = shadow `s_hld`.
  - Digit 2 dp (colon) = 1 when shadow `s_run`=0. When shadow `s_run`=1, it follows `blink`.
  - Digits 1 and 3 dp = 0.
- Blink: a frame counter increments at every frame start, modulo 2·`BLK`. `blink`=1 while the counter < `BLK`. The counter resets to 0, so the first `BLK` frames have `blink`=1.
- Polarity is applied only at the output registers. Internal logic is active-high.

## Timing
- All outputs are registered. They change on the same edge as the FSM state they reflect, with zero added latency.
- During and after reset: `dig`, `seg`, `dp` are off (at inactive levels), `frame`=0, `cnt`=0, `idx`=3, frame counter=0, shadows=0.
- Reset state:
  - With gap enabled: `GAP` with idx=3. The first edge after reset release starts a `BLN`-cycle blank, then `SHOW(0)`.
  - Without gap: the first edge after release enters `SHOW(0)`.
- Frame period: 4·(`DWN`+`BLN`) cycles with the gap, 4·`DWN` without it. Defaults give 1088 and 1024 cycles.
- `frame` is high exactly in the first `SHOW(0)` cycle.
- Reset asserted mid-frame: outputs turn off immediately (asynchronously). The scan restarts as after power-up.
- Two `dig` bits are never simultaneously active, including at every transition.

## Configuration
- `SEG7_SCAN_GAP_EN` defined: the `GAP` state exists and there are `BLN` blank cycles after every digit (anti-ghosting).
- Undefined: the `GAP` state, its logic and `BLN` usage are compiled out. Digits are back-to-back, and `dig` switches directly from one-hot i to one-hot i+1 on one edge.

## Structure
- Package `seg7_scan_pkg`:
  - state enum (`GAP`, `SHOW`);
  - digit index constants `DIG_SEC_0`…`DIG_MIN_1`;
  - segment off pattern `7'h00`.
- One sub-module, `seg7_scan_tmr`: a loadable down-counter producing a `last` flag. It is reloaded with `DWN-1` or `BLN-1` on each state entry.

## Test plan
- Defaults with gap, inputs `7'h3F`, `7'h06`, `7'h5B`, `7'h4F` -> `dig` sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000. Each one-hot interval is 256 cycles and each 0000 interval is 16 cycles; `seg` matches each digit; `frame` has a period of 1088.
- Change `sec_0` from `7'h3F` to `7'h06` during `SHOW(2)` -> `7'h3F` persists until the next `SHOW(0)`, which shows `7'h06`.
- `s_run`=1, `BLK`=2 -> the dp on digit 2 is lit for frames 0–1, dark for frames 2–3, lit again at frame 4. With `s_run`=0 it is lit every frame.
- `s_hld`=1 -> dp lit only during `SHOW(0)`. `SEG_POL`=0 and `DIG_POL`=0 -> all outputs inverted, and the reset/idle level is all-ones.
- Assert `rst` mid-`SHOW(1)` -> outputs off asynchronously. After release, the first `frame` occurs after 16 blank cycles.
- Build without `SEG7_SCAN_GAP_EN` -> `dig` goes directly from 0001 to 0010 on one edge, and the frame period is 1024.
